// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: pc_next input, imem request/response channel, instruction output and status.
// master = fetch unit side, slave = memory / downstream / next-PC side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_next;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic [XLEN-1:0] pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            fault;
  logic [1:0]      fault_cause;
  logic [XLEN-1:0] fault_pc;
  logic [31:0]     fetch_count;

  modport master (
    input  pc_next, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready,
    output imem_req_valid, imem_addr, pc, inst_valid, inst, inst_pc,
           fault, fault_cause, fault_pc, fetch_count
  );

  modport slave (
    output pc_next, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready,
    input  imem_req_valid, imem_addr, pc, inst_valid, inst, inst_pc,
           fault, fault_cause, fault_pc, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one imem read per instruction, sticky fault on misalign/bus error.
// Zero-wait throughput 1 inst / 3 cycles; stalls on imem_req_ready, imem_rsp_valid and inst_ready.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rstn,
  fetch_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fault_pc_q;
  logic [31:0]     inst_q;
  logic [31:0]     fetch_count_q;
  logic [1:0]      fault_cause_q;
  logic            req_valid, inst_valid, fault;

  logic rsp_ok, rsp_bad, inst_hs, target_ok;

  assign rsp_ok    = (state == WAIT) && bus.imem_rsp_valid && !bus.imem_rsp_err;
  assign rsp_bad   = (state == WAIT) && bus.imem_rsp_valid && bus.imem_rsp_err;
  assign inst_hs   = (state == HOLD) && bus.inst_ready;
  assign target_ok = (bus.pc_next[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (bus.imem_req_ready) state_nxt = WAIT;
      WAIT:    if (rsp_ok) state_nxt = HOLD;
               else if (rsp_bad) state_nxt = FAULT;
      HOLD:    if (inst_hs) state_nxt = target_ok ? REQ : FAULT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_valid  = (state == REQ);
    inst_valid = (state == HOLD);
    fault      = (state == FAULT);
  end

  // A misaligned target is reported but never loaded, so pc keeps pointing at the faulting instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      fetch_count_q <= '0;
      fault_cause_q <= 2'b00;
      fault_pc_q    <= '0;
    end else begin
      if (rsp_ok) inst_q <= bus.imem_rsp_data;
      if (rsp_bad) begin
        fault_cause_q <= 2'b10;
        fault_pc_q    <= pc_q;
      end
      if (inst_hs) begin
        fetch_count_q <= fetch_count_q + 32'd1;
        if (target_ok) begin
          pc_q <= bus.pc_next;
        end else begin
          fault_cause_q <= 2'b01;
          fault_pc_q    <= bus.pc_next;
        end
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.pc             = pc_q;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = pc_q;
  assign bus.fault          = fault;
  assign bus.fault_cause    = fault_cause_q;
  assign bus.fault_pc       = fault_pc_q;
  assign bus.fetch_count    = fetch_count_q;
endmodule
